sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Single-clock command scheduler between the SDRAM_16bit controller and its two clients: the 16KB cache write-back/fill path and the video prefetch FIFO.
- Selects one request at a time with fixed priority, drives sys_CMD/sys_ADDR, and waits for the controller acknowledge.
- Routes the resulting 16-bit data stream to the owning client: paired 32-bit words for the video queue, per-word strobes for the cache.
- Maintains the wrapping video line-buffer address.

Parameters:
VID_WORDS, 3072, number of 32-byte video bursts per frame; video address wraps at VID_WORDS-1
VID_BASE, 15'h6FF8, SDRAM base (in 8-word units) of the framebuffer
VID_BURST, 16, 16-bit words per video read (32 bytes)
CACHE_BURST, 128, 16-bit words per cache line transfer (256 bytes)

Ports:
clk  input  1  SDRAM-domain clock (100 MHz)
rst  input  1  synchronous, active-low reset
vid_low  input  1  video FIFO almost-empty (level)
vid_restart  input  1  pulse: restart video address at 0 at next burst boundary
cache_wr_req  input  1  cache requests 256-byte write-back (level)
cache_rd_req  input  1  cache requests 256-byte fill (level)
cache_wr_line  input  12  line address for write-back
cache_rd_line  input  12  line address for fill (CPU adr[19:8])
sys_cmd  output  2  00 nop, 01 write 256B, 10 read 32B, 11 read 256B
sys_addr  output  18  SDRAM word address
sys_cmd_ack  input  2  controller acknowledge code, held non-zero while command active
sys_rd_data_valid  input  1  sys_dout valid
sys_wr_data_valid  input  1  controller consuming a write word this cycle
sys_dout  input  16  read data
vid_data  output  32  paired video word, {second, first}
vid_we  output  1  one-cycle write strobe to video FIFO
cache_fill_we  output  1  write sys_dout into cache this cycle
cache_drain_re  output  1  cache must present next write-back word
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; sys_cmd=00; vidadr=0; pair phase=0; word count=0.
  - vid_we=0, cache_fill_we=0, cache_drain_re=0, vid_data=0, restart_pending=0.
  - Applies mid-burst too: the in-flight burst is abandoned and the SDRAM controller is reset alongside.
- FSM states:
  - IDLE: sys_cmd=00. Priority is vid_low > cache_wr_req > cache_rd_req. The winner's code and address are registered and the FSM moves to ISSUE. With no request, it stays in IDLE.
  - ISSUE: sys_cmd holds the latched code, and sys_addr is stable. Acknowledge is detected on the first cycle sys_cmd_ack != 00 following a cycle where it was 00 (registered edge detect). On acknowledge: sys_cmd becomes 00 next cycle. Code 10 → VDATA; codes 01/11 → CDATA.
  - VDATA: counts sys_rd_data_valid words.
    - Even word: latched into the low half.
    - Odd word: vid_data={sys_dout, low half} and vid_we=1 for one cycle, registered 1 cycle after the valid.
    - After VID_BURST words: vidadr advances, → IDLE.
  - CDATA:
    - cache_fill_we = sys_rd_data_valid and cache_drain_re = sys_wr_data_valid, both combinational pass-through with 0 latency.
    - After CACHE_BURST valid words of either kind → IDLE.
- Address mapping:
  - write: {cache_wr_line, 6'b0}
  - fill: {cache_rd_line, 6'b0}
  - video: {VID_BASE + {3'b0, ~vidadr[11:2], vidadr[1:0]}, 3'b000}, 15-bit add truncating, then zero-padded low bits.
- vidadr wrap: at the end of a video burst, vidadr==VID_WORDS-1 → 0, else +1.
- vid_restart:
  - Sets restart_pending.
  - At the end of the next video burst, vidadr=0 instead of increment, and restart_pending clears.
  - If restart_pending is set while IDLE, vidadr=0 immediately.
- Simultaneous events:
  - New requests are ignored while busy.
  - A request deasserted during ISSUE does not abort the command.
  - vid_low wins over pending cache requests at every IDLE decision.
- Stray data: sys_rd_data_valid in IDLE or ISSUE is ignored, with no strobes.

Decomposition:
- Shared package sdram_pkg holds:
  - command codes CMD_NOP/CMD_WR256/CMD_RD32/CMD_RD256
  - the state enum
  - VID_BURST/CACHE_BURST defaults
- One sub-module, vid_word_packer: 16→32-bit pairing, vid_we generation, phase reset on burst start.

Test Plan:
- Video read: vid_low=1, vidadr=0 → sys_cmd=10, sys_addr={15'h6FF8+{3'b0,10'h3FF,2'b00},3'b0}. After ack and 16 words 0x0001..0x0010 → 8 vid_we pulses, first vid_data=0x00020001, vidadr=1.
- Priority: vid_low, cache_wr_req and cache_rd_req all asserted in IDLE → sequence 10, then 01 (addr {cache_wr_line,6'b0}), then 11.
- Cache fill: cache_rd_line=12'hABC → sys_addr=18'h2AF00. 128 valids → 128 cache_fill_we, zero vid_we, then busy=0.
- Wrap: vidadr preset via 3071 bursts → next burst uses vidadr 3071, then vidadr=0. vid_restart mid-burst → vidadr=0 after that burst.
- Reset mid-CDATA after 40 words: rst=0 for one cycle → sys_cmd=00, all strobes 0, state IDLE, vidadr=0.
- Ack protocol: ack held at 10 for 20 cycles → exactly one transition to VDATA. Stray sys_rd_data_valid in IDLE → no strobes.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared command codes, FSM state encodings and burst defaults for the SDRAM port arbiter.
package sdram_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR256 = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_VDATA = 2'd2;
    localparam logic [1:0] ST_CDATA = 2'd3;

    localparam int          VID_WORDS_DEF   = 3072;
    localparam logic [14:0] VID_BASE_DEF    = 15'h6FF8;
    localparam int          VID_BURST_DEF   = 16;
    localparam int          CACHE_BURST_DEF = 128;

    // Framebuffer rows are laid out bottom-up in 4-burst groups, hence the inverted upper bits.
    function automatic logic [17:0] vid_sdram_addr(input logic [14:0] base,
                                                    input logic [11:0] vidadr);
        logic [14:0] w_unit;
        w_unit = base + {3'b000, ~vidadr[11:2], vidadr[1:0]};
        return {w_unit, 3'b000};
    endfunction

endpackage

// File: rtl/vid_word_packer.sv
// Pairs consecutive 16-bit SDRAM read words into 32-bit video FIFO writes {second, first}.
module vid_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic [31:0] o_vid_data,
    output logic        o_vid_we
);

    logic        r_phase;
    logic [15:0] r_low;
    logic [31:0] r_vid_data;
    logic        r_vid_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase    <= 1'b0;
            r_low      <= '0;
            r_vid_data <= '0;
            r_vid_we   <= 1'b0;
        end else begin
            r_vid_we <= 1'b0;
            if (i_start) begin
                r_phase <= 1'b0;
            end else if (i_valid) begin
                if (!r_phase) begin
                    r_low   <= i_data;
                    r_phase <= 1'b1;
                end else begin
                    r_vid_data <= {i_data, r_low};
                    r_vid_we   <= 1'b1;
                    r_phase    <= 1'b0;
                end
            end
        end
    end

    assign o_vid_data = r_vid_data;
    assign o_vid_we   = r_vid_we;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Fixed-priority scheduler sharing the SDRAM controller between video prefetch and cache line traffic.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int          VID_WORDS   = VID_WORDS_DEF,
    parameter logic [14:0] VID_BASE    = VID_BASE_DEF,
    parameter int          VID_BURST   = VID_BURST_DEF,
    parameter int          CACHE_BURST = CACHE_BURST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_low,
    input  logic        vid_restart,
    input  logic        cache_wr_req,
    input  logic        cache_rd_req,
    input  logic [11:0] cache_wr_line,
    input  logic [11:0] cache_rd_line,
    output logic [1:0]  sys_cmd,
    output logic [17:0] sys_addr,
    input  logic [1:0]  sys_cmd_ack,
    input  logic        sys_rd_data_valid,
    input  logic        sys_wr_data_valid,
    input  logic [15:0] sys_dout,
    output logic [31:0] vid_data,
    output logic        vid_we,
    output logic        cache_fill_we,
    output logic        cache_drain_re,
    output logic        busy
);

    localparam int CNT_W = $clog2((CACHE_BURST > VID_BURST) ? CACHE_BURST : VID_BURST);

    logic [1:0]       r_state;
    logic [1:0]       r_sys_cmd;
    logic [17:0]      r_sys_addr;
    logic [11:0]      r_vidadr;
    logic [CNT_W-1:0] r_count;
    logic             r_ack_prev;
    logic             r_restart_pending;

    logic             w_ack_rise;
    logic             w_vid_start;
    logic             w_vid_valid;
    logic             w_cache_valid;
    logic             w_vid_last;
    logic             w_cache_last;
    logic             w_restart_clear;
    logic [11:0]      w_vidadr_eff;

    // A held acknowledge must not retrigger, so only the 00 -> non-zero edge counts.
    assign w_ack_rise      = (sys_cmd_ack != 2'b00) && !r_ack_prev;
    assign w_vid_start     = (r_state == ST_ISSUE) && w_ack_rise && (r_sys_cmd == CMD_RD32);
    assign w_vid_valid     = (r_state == ST_VDATA) && sys_rd_data_valid;
    assign w_cache_valid   = (r_state == ST_CDATA) && (sys_rd_data_valid || sys_wr_data_valid);
    assign w_vid_last      = w_vid_valid && (r_count == CNT_W'(VID_BURST - 1));
    assign w_cache_last    = w_cache_valid && (r_count == CNT_W'(CACHE_BURST - 1));
    assign w_restart_clear = (r_state == ST_IDLE) || w_vid_last;
    assign w_vidadr_eff    = r_restart_pending ? 12'd0 : r_vidadr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= ST_IDLE;
            r_sys_cmd         <= CMD_NOP;
            r_sys_addr        <= '0;
            r_vidadr          <= '0;
            r_count           <= '0;
            r_ack_prev        <= 1'b0;
            r_restart_pending <= 1'b0;
        end else begin
            r_ack_prev <= (sys_cmd_ack != 2'b00);

            if (vid_restart)
                r_restart_pending <= 1'b1;
            else if (w_restart_clear)
                r_restart_pending <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_restart_pending)
                        r_vidadr <= '0;
                    if (vid_low) begin
                        r_sys_cmd  <= CMD_RD32;
                        r_sys_addr <= vid_sdram_addr(VID_BASE, w_vidadr_eff);
                        r_state    <= ST_ISSUE;
                    end else if (cache_wr_req) begin
                        r_sys_cmd  <= CMD_WR256;
                        r_sys_addr <= {cache_wr_line, 6'b000000};
                        r_state    <= ST_ISSUE;
                    end else if (cache_rd_req) begin
                        r_sys_cmd  <= CMD_RD256;
                        r_sys_addr <= {cache_rd_line, 6'b000000};
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_ack_rise) begin
                        r_sys_cmd <= CMD_NOP;
                        r_count   <= '0;
                        r_state   <= (r_sys_cmd == CMD_RD32) ? ST_VDATA : ST_CDATA;
                    end
                end
                ST_VDATA: begin
                    if (w_vid_last) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                        if (r_restart_pending || (r_vidadr == 12'(VID_WORDS - 1)))
                            r_vidadr <= '0;
                        else
                            r_vidadr <= r_vidadr + 12'd1;
                    end else if (w_vid_valid) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_CDATA: begin
                    if (w_cache_last) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_cache_valid) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    vid_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_vid_start),
        .i_valid   (w_vid_valid),
        .i_data    (sys_dout),
        .o_vid_data(vid_data),
        .o_vid_we  (vid_we)
    );

    assign sys_cmd        = r_sys_cmd;
    assign sys_addr       = r_sys_addr;
    assign cache_fill_we  = (r_state == ST_CDATA) && sys_rd_data_valid;
    assign cache_drain_re = (r_state == ST_CDATA) && sys_wr_data_valid;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: table of single-request transactions plus hand sequences for ack, reset, restart and wrap.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_low, vid_restart, cache_wr_req, cache_rd_req;
    logic [11:0] cache_wr_line, cache_rd_line;
    logic [1:0]  sys_cmd;
    logic [17:0] sys_addr;
    logic [1:0]  sys_cmd_ack;
    logic        sys_rd_data_valid, sys_wr_data_valid;
    logic [15:0] sys_dout;
    logic [31:0] vid_data;
    logic        vid_we, cache_fill_we, cache_drain_re, busy;

    int n_checks = 0;
    int n_fail   = 0;

    int          vid_cnt   = 0;
    int          fill_cnt  = 0;
    int          drain_cnt = 0;
    logic [31:0] vid_log [0:15];

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .vid_low          (vid_low),
        .vid_restart      (vid_restart),
        .cache_wr_req     (cache_wr_req),
        .cache_rd_req     (cache_rd_req),
        .cache_wr_line    (cache_wr_line),
        .cache_rd_line    (cache_rd_line),
        .sys_cmd          (sys_cmd),
        .sys_addr         (sys_addr),
        .sys_cmd_ack      (sys_cmd_ack),
        .sys_rd_data_valid(sys_rd_data_valid),
        .sys_wr_data_valid(sys_wr_data_valid),
        .sys_dout         (sys_dout),
        .vid_data         (vid_data),
        .vid_we           (vid_we),
        .cache_fill_we    (cache_fill_we),
        .cache_drain_re   (cache_drain_re),
        .busy             (busy)
    );

    always @(negedge clk) begin
        if (vid_we) begin
            vid_log[vid_cnt[3:0]] <= vid_data;
            vid_cnt <= vid_cnt + 1;
        end
        if (cache_fill_we)  fill_cnt  <= fill_cnt + 1;
        if (cache_drain_re) drain_cnt <= drain_cnt + 1;
    end

    typedef struct {
        logic        vl, wr, rd;
        logic [11:0] wl, rl;
        logic [1:0]  cmd;
        logic [17:0] addr;
        int          nwords;
        int          exp_vid, exp_fill, exp_drain;
        logic [31:0] first_vid;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic vl, wr, rd, input logic [11:0] wl, rl,
                                input logic [1:0] cmd, input logic [17:0] addr, input int nwords,
                                input int ev, ef, ed, input logic [31:0] fv);
        vec_t v;
        v.vl = vl; v.wr = wr; v.rd = rd; v.wl = wl; v.rl = rl;
        v.cmd = cmd; v.addr = addr; v.nwords = nwords;
        v.exp_vid = ev; v.exp_fill = ef; v.exp_drain = ed; v.first_vid = fv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic vl, wr, rd, input logic [11:0] wl, rl);
        vid_low = vl; cache_wr_req = wr; cache_rd_req = rd;
        cache_wr_line = wl; cache_rd_line = rl;
        tick();
        vid_low = 1'b0; cache_wr_req = 1'b0; cache_rd_req = 1'b0;
    endtask

    task automatic stream(input int n, input logic use_wr, input int restart_at);
        for (int k = 0; k < n; k++) begin
            sys_dout          = 16'(k + 1);
            sys_rd_data_valid = !use_wr;
            sys_wr_data_valid = use_wr;
            vid_restart       = (k == restart_at);
            tick();
        end
        sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
        vid_restart = 1'b0; sys_dout = '0;
    endtask

    task automatic video_burst(input string name, input logic [17:0] exp_addr, input int restart_at);
        int v0;
        v0 = vid_cnt;
        request(1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
        check({name, "_cmd"}, 32'(sys_cmd), 32'h2);
        check({name, "_addr"}, 32'(sys_addr), 32'(exp_addr));
        sys_cmd_ack = 2'b10;
        tick();
        stream(16, 1'b0, restart_at);
        sys_cmd_ack = 2'b00;
        tick();
        tick();
        check({name, "_vid_we_count"}, 32'(vid_cnt - v0), 32'd8);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic fast_burst();
        vid_low = 1'b1;
        tick();
        vid_low = 1'b0;
        sys_cmd_ack = 2'b10;
        tick();
        sys_rd_data_valid = 1'b1;
        repeat (16) tick();
        sys_rd_data_valid = 1'b0;
        sys_cmd_ack = 2'b00;
    endtask

    initial begin
        int v0, f0, d0, cnt_cmd, cnt_idle;

        vecs[0] = mk(1, 0, 0, 12'h000, 12'h000, 2'b10, 18'h3FFA0, 16, 8, 0, 0, 32'h00020001);
        vecs[1] = mk(1, 0, 0, 12'h000, 12'h000, 2'b10, 18'h3FFA8, 16, 8, 0, 0, 32'h00020001);
        vecs[2] = mk(1, 1, 1, 12'h123, 12'hABC, 2'b10, 18'h3FFB0, 16, 8, 0, 0, 32'h00020001);
        vecs[3] = mk(0, 1, 1, 12'h123, 12'hABC, 2'b01, 18'h048C0, 128, 0, 0, 128, 32'h0);
        vecs[4] = mk(0, 0, 1, 12'h123, 12'hABC, 2'b11, 18'h2AF00, 128, 0, 128, 0, 32'h0);
        vecs[5] = mk(0, 1, 0, 12'hFFF, 12'h000, 2'b01, 18'h3FFC0, 128, 0, 0, 128, 32'h0);

        rst = 1'b0; vid_low = 0; vid_restart = 0; cache_wr_req = 0; cache_rd_req = 0;
        cache_wr_line = '0; cache_rd_line = '0; sys_cmd_ack = 2'b00;
        sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = '0;
        tick();
        tick();
        check("reset_sys_cmd", 32'(sys_cmd), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_vid_we", 32'(vid_we), 32'h0);
        check("reset_vid_data", vid_data, 32'h0);
        rst = 1'b1;
        tick();

        // Stray data while idle must not produce strobes.
        f0 = fill_cnt; d0 = drain_cnt; v0 = vid_cnt;
        sys_rd_data_valid = 1; sys_wr_data_valid = 1; sys_dout = 16'h5555;
        repeat (3) tick();
        check("stray_idle_fill_now", 32'(cache_fill_we), 32'h0);
        sys_rd_data_valid = 0; sys_wr_data_valid = 0;
        tick();
        tick();
        check("stray_idle_fill", 32'(fill_cnt - f0), 32'h0);
        check("stray_idle_drain", 32'(drain_cnt - d0), 32'h0);
        check("stray_idle_vid", 32'(vid_cnt - v0), 32'h0);
        check("stray_idle_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 6; i++) begin
            v0 = vid_cnt; f0 = fill_cnt; d0 = drain_cnt;
            request(vecs[i].vl, vecs[i].wr, vecs[i].rd, vecs[i].wl, vecs[i].rl);
            check($sformatf("vec%0d_cmd", i), 32'(sys_cmd), 32'(vecs[i].cmd));
            check($sformatf("vec%0d_addr", i), 32'(sys_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h1);
            tick();
            check($sformatf("vec%0d_cmd_hold", i), 32'(sys_cmd), 32'(vecs[i].cmd));
            sys_cmd_ack = vecs[i].cmd;
            tick();
            check($sformatf("vec%0d_cmd_after_ack", i), 32'(sys_cmd), 32'h0);
            stream(vecs[i].nwords, vecs[i].cmd == 2'b01, -1);
            sys_cmd_ack = 2'b00;
            tick();
            tick();
            check($sformatf("vec%0d_busy_end", i), 32'(busy), 32'h0);
            check($sformatf("vec%0d_vid_we", i), 32'(vid_cnt - v0), 32'(vecs[i].exp_vid));
            check($sformatf("vec%0d_fill_we", i), 32'(fill_cnt - f0), 32'(vecs[i].exp_fill));
            check($sformatf("vec%0d_drain_re", i), 32'(drain_cnt - d0), 32'(vecs[i].exp_drain));
            if (vecs[i].exp_vid > 0) begin
                check($sformatf("vec%0d_first_vid_data", i), vid_log[v0[3:0]], vecs[i].first_vid);
                check($sformatf("vec%0d_last_vid_data", i), vid_log[4'(v0 + 7)], 32'h0010000F);
            end
        end

        // Long-held ack: one entry into VDATA, no re-issue; stray valid during ISSUE ignored.
        v0 = vid_cnt;
        request(1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
        check("ack_addr", 32'(sys_addr), 32'h3FFB8);
        sys_rd_data_valid = 1; sys_dout = 16'hDEAD;
        tick();
        sys_rd_data_valid = 0;
        sys_cmd_ack = 2'b10;
        cnt_cmd = 0; cnt_idle = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (sys_cmd != 2'b00) cnt_cmd++;
            if (!busy) cnt_idle++;
        end
        check("ack_held_reissue", 32'(cnt_cmd), 32'h0);
        check("ack_held_left_vdata", 32'(cnt_idle), 32'h0);
        stream(15, 1'b0, -1);
        check("ack_busy_after_15", 32'(busy), 32'h1);
        stream(1, 1'b0, -1);
        sys_cmd_ack = 2'b00;
        tick();
        tick();
        check("ack_busy_end", 32'(busy), 32'h0);
        check("ack_vid_we", 32'(vid_cnt - v0), 32'd8);
        check("ack_first_vid_data", vid_log[v0[3:0]], 32'h00020001);

        // Reset in the middle of a cache fill.
        f0 = fill_cnt;
        request(1'b0, 1'b0, 1'b1, 12'h000, 12'hABC);
        sys_cmd_ack = 2'b11;
        tick();
        stream(40, 1'b0, -1);
        check("rst_fill_40", 32'(fill_cnt - f0), 32'd40);
        sys_rd_data_valid = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_mid_sys_cmd", 32'(sys_cmd), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_fill_we", 32'(cache_fill_we), 32'h0);
        check("rst_mid_vid_we", 32'(vid_we), 32'h0);
        sys_rd_data_valid = 1'b0;
        sys_cmd_ack = 2'b00;
        tick();
        video_burst("rst_vidadr0", 18'h3FFA0, -1);

        // Restart mid-burst, then restart while idle.
        video_burst("restart_mid", 18'h3FFA8, 5);
        video_burst("restart_mid_next", 18'h3FFA0, -1);
        vid_restart = 1'b1;
        tick();
        vid_restart = 1'b0;
        tick();
        video_burst("restart_idle", 18'h3FFA0, -1);

        // Wrap at the last burst of the frame.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        v0 = vid_cnt;
        for (int b = 0; b < 3071; b++) fast_burst();
        tick();
        check("wrap_fast_vid_we", 32'(vid_cnt - v0), 32'd24568);
        video_burst("wrap_last", 18'h39FD8, -1);
        video_burst("wrap_first", 18'h3FFA0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
